ctrl_pipe: RTL and testbench

CTRL_PIPE -- requirements
Module: ctrl_pipe

---
 rtl/ctrl_pkg.sv | 70 +++++++
 rtl/ctrl_pipe_hazard_detect.sv | 61 ++++++
 rtl/ctrl_pipe.sv | 113 +++++++++++
 tb/tb_ctrl_pipe.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared control-word layout, stage record and opcode constants for the
// decode-to-writeback control pipeline.
package ctrl_pkg;

  localparam int CTRL_W       = 20;
  localparam int TAG_W        = 5;

  localparam int CTRL_RSVD    = 19;
  localparam int CTRL_LOAD    = 18;
  localparam int CTRL_WRE     = 17;
  localparam int CTRL_VWRE    = 16;
  localparam int CTRL_WE_A    = 15;
  localparam int CTRL_WE_B    = 14;
  localparam int CTRL_WB_SEL  = 12;
  localparam int CTRL_WB_VSEL = 10;
  localparam int CTRL_ALU_OP  = 5;
  localparam int CTRL_VALU_OP = 0;

  // Tag bit 4 selects the vector register file.
  localparam int TAG_VEC_BIT  = 4;

  typedef struct packed {
    logic       rsvd;
    logic       load;
    logic       wre;
    logic       vector_wre;
    logic       we_a;
    logic       we_b;
    logic [1:0] wb_sel;
    logic [1:0] wb_vsel;
    logic [4:0] alu_op;
    logic [4:0] valu_op;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_NOP = '0;

  typedef struct packed {
    ctrl_word_t       ctrl;
    logic [TAG_W-1:0] rd;
    logic [TAG_W-1:0] rs1;
    logic [TAG_W-1:0] rs2;
    logic             rs1_used;
    logic             rs2_used;
  } stage_t;

  localparam stage_t STAGE_NOP = '0;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  localparam logic [4:0] ALU_OP_NONE  = 5'd0;
  localparam logic [4:0] ALU_OP_ADDR  = 5'd2;
  localparam logic [4:0] ALU_OP_ADD   = 5'd4;
  localparam logic [4:0] VALU_OP_NONE = 5'd0;
  localparam logic [4:0] VALU_OP_VSTR = 5'h11;

  localparam logic [CTRL_W-1:0] CW_LDR  = 20'h60040;
  localparam logic [CTRL_W-1:0] CW_ADD  = 20'h21080;
  localparam logic [CTRL_W-1:0] CW_VSTR = 20'h04011;

  // True when a stage with these write enables updates the file named by tag.
  function automatic logic writes_file(input logic wre, input logic vwre,
                                       input logic [TAG_W-1:0] tag);
    return tag[TAG_VEC_BIT] ? vwre : wre;
  endfunction

endpackage

// File: rtl/ctrl_pipe_hazard_detect.sv
// Load-use interlock and EX operand forwarding select, purely combinational
// on the registered stage contents plus the decode-stage source tags.
module hazard_detect
  import ctrl_pkg::*;
(
  input  logic             ex_load,
  input  logic [TAG_W-1:0] ex_rd,
  input  logic [TAG_W-1:0] ex_rs1,
  input  logic [TAG_W-1:0] ex_rs2,
  input  logic             ex_rs1_used,
  input  logic             ex_rs2_used,
  input  logic             mem_load,
  input  logic             mem_wre,
  input  logic             mem_vwre,
  input  logic [TAG_W-1:0] mem_rd,
  input  logic             wb_wre,
  input  logic             wb_vwre,
  input  logic [TAG_W-1:0] wb_rd,
  input  logic [TAG_W-1:0] id_rs1,
  input  logic [TAG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             branch_taken,
  output logic             hazard_stall,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b
);

  // A load in MEM has no result yet, so it never forwards; the interlock
  // guarantees a bubble separates it from any consumer.
  function automatic logic [1:0] pick_src(
    input logic [TAG_W-1:0] src, input logic used,
    input logic m_load, input logic m_wre, input logic m_vwre, input logic [TAG_W-1:0] m_rd,
    input logic w_wre, input logic w_vwre, input logic [TAG_W-1:0] w_rd
  );
    logic mem_hit;
    logic wb_hit;
    mem_hit = used && !m_load && (m_rd == src) && writes_file(m_wre, m_vwre, src);
    wb_hit  = used && (w_rd == src) && writes_file(w_wre, w_vwre, src);
    if (mem_hit)     return FWD_MEM;
    else if (wb_hit) return FWD_WB;
    else             return FWD_RF;
  endfunction

  logic rs1_dep;
  logic rs2_dep;

  always_comb begin
    rs1_dep      = id_rs1_used && (id_rs1 == ex_rd);
    rs2_dep      = id_rs2_used && (id_rs2 == ex_rd);
    hazard_stall = ex_load && (rs1_dep || rs2_dep) && !branch_taken;
  end

  always_comb begin
    fwd_a = pick_src(ex_rs1, ex_rs1_used, mem_load, mem_wre, mem_vwre, mem_rd,
                     wb_wre, wb_vwre, wb_rd);
    fwd_b = pick_src(ex_rs2, ex_rs2_used, mem_load, mem_wre, mem_vwre, mem_rd,
                     wb_wre, wb_vwre, wb_rd);
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Control pipeline EX/MEM/WB: carries decoded control words, inserts bubbles
// on load-use and taken branches, flags reserved encodings, counts bubbles.
module ctrl_pipe
  import ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [TAG_W-1:0]  id_rd,
  input  logic [TAG_W-1:0]  id_rs1,
  input  logic [TAG_W-1:0]  id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic              stall_ext,
  input  logic              branch_taken,
  output logic              hazard_stall,
  output logic [4:0]        ex_alu_op,
  output logic [4:0]        ex_valu_op,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mem_load,
  output logic              mem_we_a,
  output logic              mem_we_b,
  output logic              wb_wre,
  output logic              wb_vwre,
  output logic [1:0]        wb_sel,
  output logic [1:0]        wb_vsel,
  output logic [TAG_W-1:0]  wb_rd,
  output logic              illegal,
  output logic [15:0]       bubble_cnt
);

  stage_t ex_q;
  stage_t mem_q;
  stage_t wb_q;
  stage_t id_entry;
  logic   insert_bubble;

  always_comb begin
    id_entry          = STAGE_NOP;
    id_entry.ctrl     = ctrl_word_t'(id_ctrl);
    id_entry.rd       = id_rd;
    id_entry.rs1      = id_rs1;
    id_entry.rs2      = id_rs2;
    id_entry.rs1_used = id_rs1_used;
    id_entry.rs2_used = id_rs2_used;
  end

  hazard_detect u_hazard (
    .ex_load      (ex_q.ctrl.load),
    .ex_rd        (ex_q.rd),
    .ex_rs1       (ex_q.rs1),
    .ex_rs2       (ex_q.rs2),
    .ex_rs1_used  (ex_q.rs1_used),
    .ex_rs2_used  (ex_q.rs2_used),
    .mem_load     (mem_q.ctrl.load),
    .mem_wre      (mem_q.ctrl.wre),
    .mem_vwre     (mem_q.ctrl.vector_wre),
    .mem_rd       (mem_q.rd),
    .wb_wre       (wb_q.ctrl.wre),
    .wb_vwre      (wb_q.ctrl.vector_wre),
    .wb_rd        (wb_q.rd),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .branch_taken (branch_taken),
    .hazard_stall (hazard_stall),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b)
  );

  assign insert_bubble = branch_taken || hazard_stall;

  // External stall freezes everything, including the bubble counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q       <= STAGE_NOP;
      mem_q      <= STAGE_NOP;
      wb_q       <= STAGE_NOP;
      illegal    <= 1'b0;
      bubble_cnt <= '0;
    end else if (!stall_ext) begin
      mem_q <= ex_q;
      wb_q  <= mem_q;
      if (insert_bubble) begin
        ex_q <= STAGE_NOP;
        if (bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
      end else if (id_ctrl[CTRL_RSVD]) begin
        ex_q    <= STAGE_NOP;
        illegal <= 1'b1;
      end else begin
        ex_q <= id_entry;
      end
    end
  end

  assign ex_alu_op  = ex_q.ctrl.alu_op;
  assign ex_valu_op = ex_q.ctrl.valu_op;
  assign mem_load   = mem_q.ctrl.load;
  assign mem_we_a   = mem_q.ctrl.we_a;
  assign mem_we_b   = mem_q.ctrl.we_b;
  assign wb_wre     = wb_q.ctrl.wre;
  assign wb_vwre    = wb_q.ctrl.vector_wre;
  assign wb_sel     = wb_q.ctrl.wb_sel;
  assign wb_vsel    = wb_q.ctrl.wb_vsel;
  assign wb_rd      = wb_q.rd;

  // WB keeps the full record for observability; only part of it drives ports.
  logic unused_wb_bits;
  assign unused_wb_bits = ^wb_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: scoreboard of expected stage contents,
// directed hazard/forward/flush/stall/reserved/reset scenarios plus random traffic.
module tb_ctrl_pipe;
  import ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [19:0] id_ctrl = '0;
  logic [4:0]  id_rd = '0;
  logic [4:0]  id_rs1 = '0;
  logic [4:0]  id_rs2 = '0;
  logic        id_rs1_used = 1'b0;
  logic        id_rs2_used = 1'b0;
  logic        stall_ext = 1'b0;
  logic        branch_taken = 1'b0;
  logic        hazard_stall;
  logic [4:0]  ex_alu_op;
  logic [4:0]  ex_valu_op;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic        mem_load;
  logic        mem_we_a;
  logic        mem_we_b;
  logic        wb_wre;
  logic        wb_vwre;
  logic [1:0]  wb_sel;
  logic [1:0]  wb_vsel;
  logic [4:0]  wb_rd;
  logic        illegal;
  logic [15:0] bubble_cnt;

  localparam logic [19:0] C_LDR  = 20'h60040;
  localparam logic [19:0] C_ADD  = 20'h21080;
  localparam logic [19:0] C_VSTR = 20'h04011;
  localparam logic [19:0] C_RSV  = 20'hA0000;
  localparam logic [19:0] C_VW   = 20'h10403;
  localparam logic [19:0] C_NOP  = 20'h00000;

  always #5 clk = ~clk;

  ctrl_pipe dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_ctrl      (id_ctrl),
    .id_rd        (id_rd),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .stall_ext    (stall_ext),
    .branch_taken (branch_taken),
    .hazard_stall (hazard_stall),
    .ex_alu_op    (ex_alu_op),
    .ex_valu_op   (ex_valu_op),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .mem_load     (mem_load),
    .mem_we_a     (mem_we_a),
    .mem_we_b     (mem_we_b),
    .wb_wre       (wb_wre),
    .wb_vwre      (wb_vwre),
    .wb_sel       (wb_sel),
    .wb_vsel      (wb_vsel),
    .wb_rd        (wb_rd),
    .illegal      (illegal),
    .bubble_cnt   (bubble_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Entry = {ctrl[19:0], rd[4:0]}; queue holds expected {MEM, EX} between edges.
  logic [24:0] exp_q[$];
  logic [24:0] wb_held;
  int          exp_bub;
  logic        exp_ill;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] wb_view(input logic [24:0] e);
    logic [19:0] c;
    c = e[24:5];
    return {c[17], c[16], c[13:12], c[11:10], e[4:0]};
  endfunction

  function automatic logic [2:0] mem_view(input logic [24:0] e);
    logic [19:0] c;
    c = e[24:5];
    return {c[18], c[15], c[14]};
  endfunction

  function automatic logic [9:0] ex_view(input logic [24:0] e);
    logic [19:0] c;
    c = e[24:5];
    return c[9:0];
  endfunction

  task automatic reset_model();
    exp_q.delete();
    exp_q.push_back('0);
    exp_q.push_back('0);
    wb_held = '0;
    exp_bub = 0;
    exp_ill = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ctrl"}, 32'({hazard_stall, ex_alu_op, ex_valu_op, fwd_a, fwd_b,
                                  mem_load, mem_we_a, mem_we_b, wb_wre, wb_vwre,
                                  wb_sel, wb_vsel, wb_rd}), 32'd0);
    check_eq({tag, "_illegal"}, 32'(illegal), 32'd0);
    check_eq({tag, "_bubble"}, 32'(bubble_cnt), 32'd0);
  endtask

  // Called at posedge+1; drives one id entry, checks the interlock mid-cycle,
  // then checks every stage right after the edge.
  task automatic step(input logic [19:0] c, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic u1, input logic u2,
                      input logic br, input logic st, input logic exp_haz,
                      input logic [1:0] efa, input logic [1:0] efb);
    logic [24:0] ent;
    id_ctrl = c; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_rs1_used = u1; id_rs2_used = u2; branch_taken = br; stall_ext = st;
    @(negedge clk);
    check_eq("hazard_stall", 32'(hazard_stall), 32'(exp_haz));
    @(posedge clk);
    #1;
    if (!st) begin
      if (br || exp_haz) begin
        ent = '0;
        if (exp_bub < 65535) exp_bub++;
      end else if (c[19]) begin
        ent = '0;
        exp_ill = 1'b1;
      end else begin
        ent = {c, rd};
      end
      exp_q.push_back(ent);
      wb_held = exp_q.pop_front();
    end
    check_eq("wb_stage", 32'({wb_wre, wb_vwre, wb_sel, wb_vsel, wb_rd}), 32'(wb_view(wb_held)));
    check_eq("mem_stage", 32'({mem_load, mem_we_a, mem_we_b}), 32'(mem_view(exp_q[0])));
    check_eq("ex_stage", 32'({ex_alu_op, ex_valu_op}), 32'(ex_view(exp_q[1])));
    check_eq("fwd_a", 32'(fwd_a), 32'(efa));
    check_eq("fwd_b", 32'(fwd_b), 32'(efb));
    check_eq("illegal", 32'(illegal), 32'(exp_ill));
    check_eq("bubble_cnt", 32'(bubble_cnt), 32'(exp_bub));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(C_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
  endtask

  initial begin
    logic [19:0] rc;
    logic        rbr;
    logic        rst;

    reset_model();
    #2;
    check_all_zero("reset_state");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Load-use: one bubble, then WB forwarding of the load result.
    step(C_LDR, 5'h03, 5'h00, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step(C_ADD, 5'h04, 5'h03, 5'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
    step(C_ADD, 5'h04, 5'h03, 5'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00);
    check_eq("load_use_bubbles", 32'(bubble_cnt), 32'd1);

    // Back-to-back ALU: MEM forwarding, no stall.
    step(C_ADD, 5'h02, 5'h00, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step(C_ADD, 5'h05, 5'h00, 5'h02, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01);

    // MEM beats WB when both hold the same destination; then WB-only match.
    step(C_ADD, 5'h06, 5'h00, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step(C_ADD, 5'h06, 5'h00, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step(C_ADD, 5'h07, 5'h06, 5'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00);
    step(C_NOP, 5'h00, 5'h00, 5'h06, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10);

    // Vector file: vector_wre forwards, a scalar write to a vector tag does not.
    step(C_VW,  5'h11, 5'h00, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step(C_ADD, 5'h08, 5'h11, 5'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00);
    step(C_ADD, 5'h12, 5'h00, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step(C_NOP, 5'h00, 5'h00, 5'h12, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);

    // Branch flush of a vstr; then a branch masking a load-use hazard.
    step(C_VSTR, 5'h00, 5'h00, 5'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    idle(3);
    step(C_LDR, 5'h09, 5'h00, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step(C_ADD, 5'h0A, 5'h09, 5'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    idle(1);

    // External stall for 3 cycles while a load-use interlock is pending.
    step(C_ADD, 5'h0D, 5'h00, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step(C_LDR, 5'h08, 5'h00, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    for (int i = 0; i < 3; i++)
      step(C_ADD, 5'h0B, 5'h08, 5'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00);
    step(C_ADD, 5'h0B, 5'h08, 5'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
    step(C_ADD, 5'h0B, 5'h08, 5'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00);

    // Reserved bit: becomes NOP, sets sticky illegal.
    step(C_RSV, 5'h0C, 5'h00, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    check_eq("illegal_after_edge", 32'(illegal), 32'd1);
    idle(3);

    // Random traffic without source use, so no interlock or forwarding.
    for (int i = 0; i < 40; i++) begin
      rc = 20'($urandom_range(0, 20'h7FFFF));
      if ($urandom_range(0, 7) == 0) rc[19] = 1'b1;
      rbr = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 7) == 0);
      step(rc, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           1'b0, 1'b0, rbr, rst, 1'b0, 2'b00, 2'b00);
    end
    check_eq("illegal_persists", 32'(illegal), 32'd1);

    // Reset mid-stream with every stage occupied.
    step(C_ADD, 5'h01, 5'h00, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step(C_LDR, 5'h02, 5'h00, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step(C_VW,  5'h13, 5'h00, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    id_ctrl = C_LDR; id_rd = 5'h13; id_rs1 = 5'h13; id_rs1_used = 1'b1;
    rst_n = 1'b0;
    #2;
    check_all_zero("reset_async");
    @(posedge clk);
    #1;
    check_all_zero("reset_held");
    rst_n = 1'b1;
    reset_model();
    step(C_ADD, 5'h03, 5'h00, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
